// File: rtl/header_segmenter.sv
`default_nettype none
// ============================================================================
// Module   : header_segmenter
// Purpose  : Splits one descriptor into MAX_SEG-byte segments; emits a 32-bit
//            header per segment followed by that segment's payload words.
// Revision : 1.0
// ============================================================================
module header_segmenter #(
    parameter int DW      = 32,
    parameter int LEN_W   = 32,
    parameter int MAX_SEG = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_dtype,
    input  logic             cmd_eot,
    input  logic             cmd_eoi,
    input  logic             cmd_last,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [DW-1:0]    din_data,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [DW-1:0]    dout_data,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy
);

    localparam int c_BYTES     = DW / 8;
    localparam int c_MAX_WORDS = (MAX_SEG + c_BYTES - 1) / c_BYTES;
    localparam int c_WCW       = $clog2(c_MAX_WORDS + 1);
    localparam int c_CW        = (LEN_W > 17) ? LEN_W : 17;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_dtype;
    logic                r_eot;
    logic                r_eoi;
    logic                r_last;
    logic [LEN_W-1:0]    r_rem;
    logic [c_WCW-1:0]    r_wcnt;

    logic [c_CW-1:0]     w_seg_ext;
    logic [15:0]         w_seg_len;
    logic [c_WCW-1:0]    w_words;
    logic                w_final;
    logic [31:0]         w_hdr;
    logic                w_hdr_hs;
    logic                w_dat_hs;

    // Segment length is derived from the registered remaining count, so the
    // header is stable for as long as the state sits in HDR.
    assign w_seg_ext = (c_CW'(r_rem) < c_CW'(MAX_SEG)) ? c_CW'(r_rem) : c_CW'(MAX_SEG);
    assign w_seg_len = 16'(w_seg_ext);
    assign w_words   = c_WCW'((32'(w_seg_len) + 32'(c_BYTES - 1)) / 32'(c_BYTES));
    assign w_final   = (r_rem == LEN_W'(w_seg_ext));
    assign w_hdr     = {r_dtype, 1'b0, w_final & r_eot, w_final & r_eoi,
                        w_final & r_last, 7'd0, 1'b1, w_seg_len};

    assign w_hdr_hs  = (r_state == S_HDR) && dout_ready;
    assign w_dat_hs  = (r_state == S_DATA) && din_valid && dout_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        cmd_ready  = 1'b0;
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        dout_data  = '0;
        busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next = S_HDR;
                end
            end
            S_HDR: begin
                dout_valid = 1'b1;
                dout_data  = DW'(w_hdr);
                if (dout_ready) begin
                    w_next = (w_words == '0) ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                dout_valid = din_valid;
                dout_data  = din_data;
                din_ready  = dout_ready;
                if (w_dat_hs && (r_wcnt == c_WCW'(1))) begin
                    w_next = (r_rem != '0) ? S_HDR : S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dtype <= '0;
            r_eot   <= 1'b0;
            r_eoi   <= 1'b0;
            r_last  <= 1'b0;
            r_rem   <= '0;
            r_wcnt  <= '0;
        end else begin
            if ((r_state == S_IDLE) && cmd_valid) begin
                r_dtype <= cmd_dtype;
                r_eot   <= cmd_eot;
                r_eoi   <= cmd_eoi;
                r_last  <= cmd_last;
                r_rem   <= cmd_len;
            end
            if (w_hdr_hs) begin
                r_rem  <= r_rem - LEN_W'(w_seg_ext);
                r_wcnt <= w_words;
            end else if (w_dat_hs) begin
                r_wcnt <= r_wcnt - c_WCW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_header_segmenter.sv
`default_nettype none
// ============================================================================
// Module   : tb_header_segmenter
// Purpose  : Scoreboard bench for header_segmenter (MAX_SEG=16 and 1024 DUTs).
// Revision : 1.0
// ============================================================================
module tb_header_segmenter;

    logic        clk;
    logic        rst;

    logic        cmdA_valid, cmdA_ready, cmdA_eot, cmdA_eoi, cmdA_last;
    logic [3:0]  cmdA_dtype;
    logic [31:0] cmdA_len, dinA_data, doutA_data;
    logic        dinA_valid, dinA_ready, doutA_valid, doutA_ready, busyA;

    logic        cmdB_valid, cmdB_ready, cmdB_eot, cmdB_eoi, cmdB_last;
    logic [3:0]  cmdB_dtype;
    logic [31:0] cmdB_len, dinB_data, doutB_data;
    logic        dinB_valid, dinB_ready, doutB_valid, doutB_ready, busyB;

    logic [31:0] expA[$];
    logic [31:0] expB[$];
    logic [31:0] dinA_q[$];
    logic [31:0] dinB_q[$];

    int          errors = 0;
    int          checks = 0;
    int          popA   = 0;
    int          zcnt   = 0;
    bit          zmon   = 0;
    bit          stall  = 0;

    header_segmenter #(.DW(32), .LEN_W(32), .MAX_SEG(16)) u_dut_a (
        .clk(clk), .rst(rst),
        .cmd_valid(cmdA_valid), .cmd_ready(cmdA_ready), .cmd_dtype(cmdA_dtype),
        .cmd_eot(cmdA_eot), .cmd_eoi(cmdA_eoi), .cmd_last(cmdA_last), .cmd_len(cmdA_len),
        .din_data(dinA_data), .din_valid(dinA_valid), .din_ready(dinA_ready),
        .dout_data(doutA_data), .dout_valid(doutA_valid), .dout_ready(doutA_ready),
        .busy(busyA)
    );

    header_segmenter #(.DW(32), .LEN_W(32), .MAX_SEG(1024)) u_dut_b (
        .clk(clk), .rst(rst),
        .cmd_valid(cmdB_valid), .cmd_ready(cmdB_ready), .cmd_dtype(cmdB_dtype),
        .cmd_eot(cmdB_eot), .cmd_eoi(cmdB_eoi), .cmd_last(cmdB_last), .cmd_len(cmdB_len),
        .din_data(dinB_data), .din_valid(dinB_valid), .din_ready(dinB_ready),
        .dout_data(doutB_data), .dout_valid(doutB_valid), .dout_ready(doutB_ready),
        .busy(busyB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor A: scoreboard pop plus hold check while the output is stalled.
    initial begin
        bit          pend;
        logic [31:0] hold;
        pend = 0;
        hold = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 0;
            end else begin
                if (pend && doutA_valid) chk("hold_A", doutA_data, hold);
                if (doutA_valid && doutA_ready) begin
                    if (expA.size() == 0) chk("extra_out_A", doutA_data, 32'hDEAD_BEEF);
                    else chk("out_A", doutA_data, expA.pop_front());
                    popA++;
                end
                pend = doutA_valid && !doutA_ready;
                hold = doutA_data;
            end
            if (zmon && dinA_ready) zcnt++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && doutB_valid && doutB_ready) begin
                if (expB.size() == 0) chk("extra_out_B", doutB_data, 32'hDEAD_BEEF);
                else chk("out_B", doutB_data, expB.pop_front());
            end
        end
    end

    // Payload feeders: valid is held until accepted; stalls insert random gaps.
    initial begin
        bit hs;
        dinA_valid = 1'b0;
        dinA_data  = '0;
        forever begin
            @(negedge clk);
            hs = dinA_valid && dinA_ready;
            @(posedge clk);
            #1;
            if (hs && dinA_q.size() > 0) dinA_q.delete(0);
            if (dinA_q.size() == 0) begin
                dinA_valid = 1'b0;
                dinA_data  = '0;
            end else begin
                if (!(dinA_valid && !hs)) dinA_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                dinA_data = dinA_q[0];
            end
        end
    end

    initial begin
        bit hs;
        dinB_valid = 1'b0;
        dinB_data  = '0;
        forever begin
            @(negedge clk);
            hs = dinB_valid && dinB_ready;
            @(posedge clk);
            #1;
            if (hs && dinB_q.size() > 0) dinB_q.delete(0);
            dinB_valid = (dinB_q.size() > 0);
            dinB_data  = (dinB_q.size() > 0) ? dinB_q[0] : 32'd0;
        end
    end

    initial begin
        doutA_ready = 1'b1;
        doutB_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            doutA_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_a(input logic [3:0] dt, input logic e, input logic i,
                          input logic l, input logic [31:0] len);
        int n;
        @(posedge clk);
        #1;
        cmdA_dtype = dt; cmdA_eot = e; cmdA_eoi = i; cmdA_last = l; cmdA_len = len;
        cmdA_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmdA_ready && n < 100);
        if (!cmdA_ready) chk("cmd_accept_A", {31'd0, cmdA_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmdA_valid = 1'b0;
    endtask

    task automatic drain_a(input string name);
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            if (expA.size() == 0 && !busyA) break;
        end
        chk(name, {expA.size() == 0, busyA}, 32'd2);
    endtask

    task automatic load40(input logic [31:0] base);
        for (int i = 0; i < 10; i++) dinA_q.push_back(base + 32'(i));
        expA.push_back(32'h5001_0010);
        for (int i = 0; i < 4; i++) expA.push_back(base + 32'(i));
        expA.push_back(32'h5001_0010);
        for (int i = 4; i < 8; i++) expA.push_back(base + 32'(i));
        expA.push_back(32'h5501_0008);
        for (int i = 8; i < 10; i++) expA.push_back(base + 32'(i));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd_ready"},  {31'd0, cmdA_ready},  32'd1);
        chk({tag, "_dout_valid"}, {31'd0, doutA_valid}, 32'd0);
        chk({tag, "_busy"},       {31'd0, busyA},       32'd0);
        chk({tag, "_din_ready"},  {31'd0, dinA_ready},  32'd0);
        chk({tag, "_dout_data"},  doutA_data,           32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        cmdA_valid = 1'b0; cmdA_dtype = '0; cmdA_eot = 0; cmdA_eoi = 0; cmdA_last = 0; cmdA_len = '0;
        cmdB_valid = 1'b0; cmdB_dtype = '0; cmdB_eot = 0; cmdB_eoi = 0; cmdB_last = 0; cmdB_len = '0;
        #2 rst = 1'b1;
        #1 chk_reset("rst_init");
        chk("rst_init_B_cmd_ready", {31'd0, cmdB_ready}, 32'd1);
        #10 rst = 1'b0;

        // 40 bytes, MAX_SEG=16: three segments of 16, 16, 8
        load40(32'hA000_0000);
        send_a(4'd5, 1'b1, 1'b0, 1'b1, 32'd40);
        drain_a("drain_40");

        // zero length: single header, payload never requested
        expA.push_back(32'h2201_0000);
        zcnt = 0;
        zmon = 1;
        send_a(4'd2, 1'b0, 1'b1, 1'b0, 32'd0);
        drain_a("drain_zero");
        zmon = 0;
        chk("zero_din_ready_cycles", 32'(zcnt), 32'd0);
        chk("zero_idle_cmd_ready", {31'd0, cmdA_ready}, 32'd1);

        // MAX_SEG=1024, 5 bytes: one header, two words
        dinB_q.push_back(32'h1111_0001);
        dinB_q.push_back(32'h1111_0002);
        expB.push_back(32'h3101_0005);
        expB.push_back(32'h1111_0001);
        expB.push_back(32'h1111_0002);
        @(posedge clk);
        #1;
        cmdB_dtype = 4'd3; cmdB_eot = 0; cmdB_eoi = 0; cmdB_last = 1; cmdB_len = 32'd5;
        cmdB_valid = 1'b1;
        @(posedge clk);
        #1;
        cmdB_valid = 1'b0;
        for (n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (expB.size() == 0 && !busyB) break;
        end
        chk("drain_len5", {expB.size() == 0, busyB}, 32'd2);

        // same 40-byte transfer under random backpressure and payload gaps
        stall = 1;
        load40(32'hC000_0000);
        send_a(4'd5, 1'b1, 1'b0, 1'b1, 32'd40);
        drain_a("drain_40_stall");
        stall = 0;
        repeat (2) @(posedge clk);

        // reset inside the second segment's payload
        popA = 0;
        load40(32'hE000_0000);
        send_a(4'd5, 1'b1, 1'b0, 1'b1, 32'd40);
        for (n = 0; n < 200 && popA < 7; n++) @(negedge clk);
        chk("reached_seg2_data", {31'd0, popA >= 7}, 32'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_reset("rst_mid");
        expA.delete();
        dinA_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);

        expA.push_back(32'h5001_0010);
        for (int i = 0; i < 4; i++) begin
            dinA_q.push_back(32'h7700_0000 + 32'(i));
            expA.push_back(32'h7700_0000 + 32'(i));
        end
        send_a(4'd5, 1'b0, 1'b0, 1'b0, 32'd16);
        drain_a("drain_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/header_segmenter.md
Name: header_segmenter

Overview:
Sequential successor to the combinational header encoding used by the communication protocol. Accepts one segment descriptor per transaction. Splits the total length into sub-segments of at most MAX_SEG bytes. For each sub-segment it emits a 32-bit protocol header on the output stream, then forwards that sub-segment's payload words from the input stream. Sits between the mode controller (descriptors and payload) and the external output bus.

Parameters:
DW, 32, data bus width in bits; multiple of 32, at least 32.
LEN_W, 32, width of the total-length input, in bytes.
MAX_SEG, 1024, maximum bytes per emitted segment; 1..65535; multiple of DW/8.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  descriptor valid
cmd_ready  out  1  descriptor accepted when cmd_valid & cmd_ready
cmd_dtype  in  4  data type field
cmd_eot  in  1  end-of-type flag for the whole transfer
cmd_eoi  in  1  end-of-input flag for the whole transfer
cmd_last  in  1  last flag for the whole transfer
cmd_len  in  LEN_W  total payload bytes
din_data  in  DW  payload word
din_valid  in  1  payload valid
din_ready  out  1  payload accepted
dout_data  out  DW  header or payload word
dout_valid  out  1  output valid
dout_ready  in  1  downstream ready
busy  out  1  high whenever the state is not IDLE

Behaviour:
- One clock (clk). Asynchronous, active-high reset (rst) clears all state and returns the FSM to IDLE, including mid-transfer. After reset:
  - cmd_ready=1, busy=0
  - dout_valid=0, din_ready=0, dout_data=0
  - remaining-byte counter and word counter cleared.
- Header word layout (bit 31 down to 0):
  - [31:28] dtype
  - [27] 0
  - [26] eot
  - [25] eoi
  - [24] last
  - [23:17] 0
  - [16] 1
  - [15:0] segment byte length
- When DW>32, the header occupies dout_data[31:0] and the upper bits are 0.
- Segment length = min(remaining bytes, MAX_SEG).
- eot, eoi and last are copied from the descriptor only in the final segment's header (the one where remaining bytes minus segment length equals 0). In all earlier headers they are 0. dtype is the same in every header.
- Payload words per segment = ceil(seg_len / (DW/8)). The final word may be partially filled; it is forwarded unmodified.
- FSM states:
  - IDLE:
    - cmd_ready=1.
    - On cmd_valid: latch dtype, flags and cmd_len into the remaining-byte counter; go to HDR.
  - HDR:
    - dout_valid=1; dout_data is the header computed from registered state, held stable until accepted. din_ready=0.
    - On dout_ready: subtract seg_len from the remaining counter and load the word counter.
    - If the word count is 0 (cmd_len=0 case), go to IDLE. Otherwise go to DATA.
  - DATA:
    - Combinational pass-through: dout_data=din_data, dout_valid=din_valid, din_ready=dout_ready.
    - Each handshake decrements the word counter.
    - On the handshake of the last word: go to HDR if remaining>0, else IDLE.
- cmd_len=0: exactly one header with length 0 and the descriptor flags, no payload.
- Throughput:
  - HDR to DATA transition: no bubble.
  - Back-to-back segments: no bubble.
  - Between descriptors: one idle cycle (cmd_ready is high only in IDLE).
- Output stability: while dout_valid=1 and dout_ready=0, dout_data must not change in HDR. In DATA, stability follows din_* (upstream obeys the same rule).
- Payload is never consumed in IDLE or HDR. cmd_valid is ignored outside IDLE.
- Counter widths:
  - remaining counter: LEN_W bits; no wrap, because seg_len ≤ remaining.
  - word counter: wide enough for MAX_SEG/(DW/8).

Test Plan:
- Reset: rst pulsed asynchronously (mid-cycle) → cmd_ready=1, dout_valid=0, busy=0, immediately and without a clock edge.
- DW=32, MAX_SEG=16; descriptor dtype=5, eot=1, eoi=0, last=1, len=40 → headers 0x5001_0010, 0x5001_0010, 0x5501_0008, interleaved with 4, 4 and 2 payload words respectively (10 words total, in order).
- Zero length; dtype=2, eoi=1, len=0 → single header 0x2201_0000, no din_ready assertion, then return to IDLE.
- DW=32, len=5, MAX_SEG=1024 → header length field 5, exactly 2 payload words forwarded.
- Random dout_ready and din_valid stalls on the 40-byte case → header held stable under backpressure, no word dropped or duplicated, output sequence identical to the unstalled run.
- rst asserted during the DATA state of the second segment → immediate return to IDLE. A fresh descriptor afterwards (len=16) produces a clean header 0x5001_0010 (flags 0) plus 4 words.
